// File: rtl/memory_types_pkg.sv
// Memory packet types shared by memory requesters and responders.
// Packet layout, packet type codes, responder states, len decode helper.
package memory_types_pkg;

  typedef enum logic [2:0] {
    MEM_READ  = 3'd0,
    MEM_WRITE = 3'd1
  } mem_pkt_type_e;

  localparam int MEM_PKT_W = 69;

  // mtype kept as raw bits so unknown codes still travel through intact
  typedef struct packed {
    logic [2:0]  mtype;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_pkt_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_resp_state_e;

  // len of 0 encodes a full 4-byte word
  function automatic logic [2:0] mem_len_to_bytes(
    input logic [1:0] len
  );
    return (len == 2'd0) ? 3'd4 : {1'b0, len};
  endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Byte-lane steering for one 32-bit word access.
// In: offset, len, wdata, word. Out: be, merged wword, justified rdata.
module mem_byte_lane
  import memory_types_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  len,
  input  logic [31:0] wdata,
  input  logic [31:0] word,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata
);

  logic [2:0]  nbytes;
  logic [3:0]  lane_lo;
  logic [31:0] mask;
  logic [31:0] wshift;
  logic [31:0] rshift;

  always_comb begin
    nbytes  = mem_len_to_bytes(len);
    // low nbytes lanes set; shifting by offset drops lanes above 3
    lane_lo = 4'b1111 >> (3'd4 - nbytes);
    be      = lane_lo << offset;
    mask    = '0;
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{lane_lo[i]}};
    end
    wshift = (wdata & mask) << {offset, 3'b000};
    rshift = word >> {offset, 3'b000};
    rdata  = rshift & mask;
    wword  = word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        wword[8*i +: 8] = wshift[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Responder end of the memory packet interface, one request in flight.
// Ports: clk, rst, req_val/req_rdy/req_msg in, resp_val/resp_rdy/resp_msg out.
module mem_responder
  import memory_types_pkg::*;
#(
  parameter int NUM_WORDS = 256,
  parameter int LATENCY   = 0
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     req_val,
  output logic     req_rdy,
  input  mem_pkt_t req_msg,
  output logic     resp_val,
  input  logic     resp_rdy,
  output mem_pkt_t resp_msg
);

  localparam int         IW  = $clog2(NUM_WORDS);
  localparam logic [3:0] LAT = 4'(LATENCY);

  mem_resp_state_e state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  mem_pkt_t        resp_q, resp_d;
  logic [31:0]     mem_q [NUM_WORDS];

  logic [IW-1:0] idx;
  logic [31:0]   word;
  logic [3:0]    be;
  logic [31:0]   wword;
  logic [31:0]   rdata;
  logic          mem_we;

  // upper address bits alias onto the array
  logic unused_addr;
  assign unused_addr = ^req_msg.addr[31:IW+2];

  assign idx  = req_msg.addr[IW+1:2];
  assign word = mem_q[idx];

  mem_byte_lane u_lane (
    .offset (req_msg.addr[1:0]),
    .len    (req_msg.len),
    .wdata  (req_msg.data),
    .word   (word),
    .be     (be),
    .wword  (wword),
    .rdata  (rdata)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    resp_d   = resp_q;
    req_rdy  = 1'b0;
    resp_val = 1'b0;
    mem_we   = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_rdy = 1'b1;
        if (req_val) begin
          resp_d.mtype = req_msg.mtype;
          resp_d.addr  = req_msg.addr;
          resp_d.len   = req_msg.len;
          resp_d.data  = (req_msg.mtype == MEM_READ) ? rdata : '0;
          mem_we = (req_msg.mtype == MEM_WRITE) && (|be);
          if (LAT != 4'd0) begin
            state_d = WAIT;
            cnt_d   = LAT;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        resp_val = 1'b1;
        if (resp_rdy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign resp_msg = resp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      resp_q  <= '0;
      for (int i = 0; i < NUM_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      if (mem_we) begin
        mem_q[idx] <= wword;
      end
    end
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Responder end of the memory packet interface.
- Accepts `mem_pkt_t` requests (READ/WRITE) on a val/rdy port and services them from an internal word-addressed array.
- Returns a `mem_pkt_t` response after a fixed, configurable latency.
- Serves as the behavioural/test memory behind instruction and data memory request ports. Exactly one request is outstanding at a time.

Parameters:
- NUM_WORDS, 256, number of 32-bit words in the array; power of two, at least 2.
- LATENCY, 0, extra wait cycles between request acceptance and response valid; range 0..15.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- req_val  input  1  request valid
- req_rdy  output  1  responder can accept a request
- req_msg  input  mem_pkt_t (69)  request packet
- resp_val  output  1  response valid
- resp_rdy  input  1  consumer accepts the response
- resp_msg  output  mem_pkt_t (69)  response packet

Behaviour:
- Reset, synchronous, active-high, one cycle:
  - State goes to IDLE.
  - req_rdy=1 and resp_val=0 in the cycle after reset.
  - resp_msg=0.
  - Latency counter=0.
  - All array words cleared to 0.
  - Reset asserted mid-transaction drops the pending response with no retry.
- FSM states:
  - IDLE: req_rdy=1. On req_val&req_rdy at edge T: latch the response, perform the write, then go to WAIT if LATENCY>0, else to RESP.
  - WAIT: counter loads LATENCY at T and decrements each cycle. When the counter reaches 1, go to RESP. req_rdy=0 and resp_val=0.
  - RESP: resp_val=1 and resp_msg held stable. On resp_rdy, go to IDLE. req_rdy=0.
- Timing:
  - resp_val first asserts in cycle T+1+LATENCY.
  - Peak throughput is one transaction per 2+LATENCY cycles.
  - resp_rdy may be high before resp_val; it is ignored outside RESP.
- Addressing:
  - Word index = addr[log2(NUM_WORDS)+1:2]. Higher address bits are ignored, so accesses alias.
  - Byte offset = addr[1:0].
  - nbytes = 4 when len=0, otherwise nbytes = len.
  - Active lanes run from offset through offset+nbytes-1. Lanes above 3 are dropped: not written, and read as 0. There is no cross-word access.
- READ:
  - Response data = (word >> 8*offset) masked to the low 8*nbytes bits.
  - The word is sampled at edge T.
- WRITE:
  - Low nbytes bytes of req data are shifted left by 8*offset and written to the active lanes at edge T.
  - Response data = 0.
- Other mtype codes: no array effect; response data = 0.
- Response fields:
  - mtype, addr and len are echoed from the request.
- Ordering: requests take effect in acceptance order, so a READ after a WRITE to the same word returns the new data.

Decomposition:
- Additions to memory_types_pkg:
  - `mem_pkt_type_e` already holds READ/WRITE. Add `MEM_PKT_W=69`.
  - Add a `mem_len_to_bytes()` function mapping 0 to 4.
  - Add a `mem_resp_state_e` enum (IDLE/WAIT/RESP).
- Sub-module `mem_byte_lane`:
  - Combinational.
  - Inputs: offset, len, write data, stored word.
  - Outputs: write byte-enable[3:0], merged write word, justified read data.
  - Reusable by future caches.

Test Plan:
- Reset with LATENCY=0, then WRITE addr=0x10 len=0 data=0xDEADBEEF accepted at T → resp_val at T+1; resp mtype=WRITE, data=0; READ addr=0x10 len=0 → data=0xDEADBEEF.
- Byte/half access: WRITE addr=0x11 len=1 data=0x000000AA, then READ addr=0x10 len=0 → 0xDEADAAEF. READ addr=0x12 len=2 → 0x0000DEAD.
- Lane overflow: WRITE addr=0x23 len=2 data=0x1234 → only byte 3 of word 8 becomes 0x34. READ addr=0x23 len=2 → 0x00000034.
- Latency and backpressure: LATENCY=3, request accepted at T → resp_val rises at T+4. Hold resp_rdy=0 for 5 cycles → resp_msg stable, req_rdy=0 throughout. Raise resp_rdy → req_rdy=1 the next cycle.
- Aliasing and reset: NUM_WORDS=256, WRITE addr=0x400 data=0x5 → READ addr=0x0 returns 0x5. Assert rst during WAIT → resp_val never asserts. After reset, READ addr=0x0 returns 0.
- Random back-to-back traffic (1000 transactions) with random resp_rdy stalls, checked against a byte-accurate reference model; mtype=3'd5 returns data 0 with no array change.
